// File: rtl/player_hand_if.sv
// Deck-side link of a player hand: draw requests/strobed cards in, played cards out.
interface player_hand_if;
  logic [2:0] o_draw;
  logic       i_deck_drawn;
  logic [5:0] i_deck_card;
  logic [5:0] o_play_card;
  logic       o_insert;

  modport master (
    output o_draw, o_play_card, o_insert,
    input  i_deck_drawn, i_deck_card
  );

  modport slave (
    input  o_draw, o_play_card, o_insert,
    output i_deck_drawn, i_deck_card
  );
endinterface

// File: rtl/player_hand.sv
// One player's hand: fetches cards from the deck, validates plays against the
// discard top and compacts the hand after a card leaves it.
module player_hand #(
  parameter int MAX_CARDS = 32,
  parameter int IDX_W     = 5,
  parameter int DEAL_N    = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_deal,
  input  logic [2:0]         i_draw_req,
  player_hand_if.master      deck,
  input  logic               i_play,
  input  logic [IDX_W-1:0]   i_sel,
  input  logic [5:0]         i_top_card,
  input  logic [1:0]         i_wild_color,
  output logic               o_illegal,
  output logic               o_overflow,
  output logic [5:0]         o_sel_card,
  output logic [IDX_W:0]     o_count,
  output logic               o_busy,
  output logic               o_uno
);

  typedef enum logic [1:0] {IDLE, DRAW, SHIFT} state_t;

  localparam logic [IDX_W:0] MAX_CNT  = (IDX_W+1)'(MAX_CARDS);
  localparam logic [2:0]     DEAL_CNT = 3'(DEAL_N);

  state_t             state_q, state_d;
  logic [5:0]         hand_q [MAX_CARDS];
  logic [5:0]         hand_d [MAX_CARDS];
  logic [IDX_W:0]     count_q, count_d;
  logic [2:0]         remaining_q, remaining_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [2:0]         draw_q, draw_d;
  logic [5:0]         play_card_q, play_card_d;
  logic               insert_q, insert_d;
  logic               illegal_q, illegal_d;
  logic               overflow_q, overflow_d;

  logic               sel_ok, top_wild, legal, draw_ok, sel_not_last;
  logic [5:0]         sel_card;
  logic [1:0]         eff_colour;
  logic [IDX_W:0]     count_m1, j_next;

  // Play legality; a wild top turns the chosen colour into the only match criterion.
  always_comb begin
    sel_ok       = {1'b0, i_sel} < count_q;
    sel_card     = sel_ok ? hand_q[i_sel] : 6'd0;
    top_wild     = i_top_card[3:0] >= 4'd13;
    eff_colour   = top_wild ? i_wild_color : i_top_card[5:4];
    legal        = sel_ok && ((sel_card[3:0] >= 4'd13) ||
                              (sel_card[5:4] == eff_colour) ||
                              (!top_wild && (sel_card[3:0] == i_top_card[3:0])));
    draw_ok      = (i_draw_req == 3'b001) || (i_draw_req == 3'b010) ||
                   (i_draw_req == 3'b100);
    count_m1     = count_q - 1'b1;
    sel_not_last = {1'b0, i_sel} < count_m1;
    j_next       = {1'b0, j_q} + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_deal || draw_ok)                     state_d = DRAW;
        else if (i_play && legal && sel_not_last)  state_d = SHIFT;
      end
      DRAW:    if (deck.i_deck_drawn && remaining_q == 3'd1) state_d = IDLE;
      SHIFT:   if (j_next == count_q)                         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // In SHIFT count_q already holds the post-play count, so the last move also clears the vacated slot.
  always_comb begin
    hand_d      = hand_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    j_d         = j_q;
    draw_d      = draw_q;
    play_card_d = play_card_q;
    insert_d    = 1'b0;
    illegal_d   = 1'b0;
    overflow_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_deal) begin
          for (int i = 0; i < MAX_CARDS; i++) hand_d[i] = 6'd0;
          count_d     = '0;
          remaining_d = DEAL_CNT;
          draw_d      = 3'b001;
        end else if (draw_ok) begin
          remaining_d = (i_draw_req == 3'b001) ? 3'd1 :
                        (i_draw_req == 3'b010) ? 3'd2 : 3'd4;
          draw_d      = i_draw_req;
        end else if (i_play) begin
          if (legal) begin
            play_card_d = sel_card;
            insert_d    = 1'b1;
            count_d     = count_m1;
            j_d         = i_sel;
            if (!sel_not_last) hand_d[i_sel] = 6'd0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      DRAW: begin
        if (deck.i_deck_drawn) begin
          if (count_q < MAX_CNT) begin
            hand_d[count_q[IDX_W-1:0]] = deck.i_deck_card;
            count_d = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == 3'd1) draw_d = 3'b000;
        end
      end
      SHIFT: begin
        hand_d[j_q] = hand_q[j_next[IDX_W-1:0]];
        j_d         = j_next[IDX_W-1:0];
        if (j_next == count_q) hand_d[j_next[IDX_W-1:0]] = 6'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MAX_CARDS; i++) hand_q[i] <= 6'd0;
      count_q     <= '0;
      remaining_q <= '0;
      j_q         <= '0;
      draw_q      <= '0;
      play_card_q <= '0;
      insert_q    <= 1'b0;
      illegal_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      hand_q      <= hand_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      j_q         <= j_d;
      draw_q      <= draw_d;
      play_card_q <= play_card_d;
      insert_q    <= insert_d;
      illegal_q   <= illegal_d;
      overflow_q  <= overflow_d;
    end
  end

  assign deck.o_draw      = draw_q;
  assign deck.o_play_card = play_card_q;
  assign deck.o_insert    = insert_q;
  assign o_illegal        = illegal_q;
  assign o_overflow       = overflow_q;
  assign o_sel_card       = sel_card;
  assign o_count          = count_q;
  assign o_busy           = state_q != IDLE;
  assign o_uno            = count_q == 1;

endmodule

// File: tb/tb_player_hand.sv
// Self-checking bench for player_hand: hand contents tracked in a model queue,
// played cards scoreboarded through an expectation queue.
module tb_player_hand;
  localparam int MAX_CARDS = 32;
  localparam int IDX_W     = 5;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_deal = 1'b0;
  logic [2:0]       i_draw_req = 3'b000;
  logic             i_play = 1'b0;
  logic [IDX_W-1:0] i_sel = '0;
  logic [5:0]       i_top_card = 6'd0;
  logic [1:0]       i_wild_color = 2'd0;
  logic             o_illegal, o_overflow, o_busy, o_uno;
  logic [5:0]       o_sel_card;
  logic [IDX_W:0]   o_count;

  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [5:0] model_hand[$];
  logic [5:0] exp_q[$];

  player_hand_if deck();

  player_hand #(.MAX_CARDS(MAX_CARDS), .IDX_W(IDX_W), .DEAL_N(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_deal(i_deal), .i_draw_req(i_draw_req),
    .deck(deck), .i_play(i_play), .i_sel(i_sel), .i_top_card(i_top_card),
    .i_wild_color(i_wild_color), .o_illegal(o_illegal), .o_overflow(o_overflow),
    .o_sel_card(o_sel_card), .o_count(o_count), .o_busy(o_busy), .o_uno(o_uno)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic strobe(input logic [5:0] c);
    deck.i_deck_drawn = 1'b1;
    deck.i_deck_card  = c;
    if (model_hand.size() < MAX_CARDS) model_hand.push_back(c);
    tick();
    deck.i_deck_drawn = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    model_hand.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    i_sel = '0;
    #1;
    check_cnt++; if (o_count !== 6'd0) $display("[TB] FAIL reset_count got %0d want 0", o_count); else pass_cnt++;
    check_cnt++; if (deck.o_draw !== 3'b000) $display("[TB] FAIL reset_draw got %b want 000", deck.o_draw); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", o_busy); else pass_cnt++;
    check_cnt++; if (deck.o_insert !== 1'b0) $display("[TB] FAIL reset_insert got %b want 0", deck.o_insert); else pass_cnt++;
    check_cnt++; if (o_illegal !== 1'b0 || o_overflow !== 1'b0) $display("[TB] FAIL reset_strobes got %b%b want 00", o_illegal, o_overflow); else pass_cnt++;
    check_cnt++; if (o_uno !== 1'b0) $display("[TB] FAIL reset_uno got %b want 0", o_uno); else pass_cnt++;
    check_cnt++; if (o_sel_card !== 6'd0) $display("[TB] FAIL reset_sel_card got %h want 00", o_sel_card); else pass_cnt++;
  endtask

  task automatic test_deal();
    logic [5:0] cards [7];
    cards = '{6'h00, 6'h01, 6'h12, 6'h23, 6'h34, 6'h0D, 6'h3E};
    i_deal = 1'b1;
    tick();
    i_deal = 1'b0;
    check_cnt++; if (deck.o_draw !== 3'b001 || o_busy !== 1'b1) $display("[TB] FAIL deal_start got draw=%b busy=%b want 001/1", deck.o_draw, o_busy); else pass_cnt++;
    for (int k = 0; k < 7; k++) begin
      strobe(cards[k]);
      if (k < 6) begin
        check_cnt++; if (deck.o_draw !== 3'b001) $display("[TB] FAIL deal_draw_hold got %b want 001 after strobe %0d", deck.o_draw, k); else pass_cnt++;
      end
    end
    check_cnt++; if (deck.o_draw !== 3'b000 || o_busy !== 1'b0) $display("[TB] FAIL deal_end got draw=%b busy=%b want 000/0", deck.o_draw, o_busy); else pass_cnt++;
    check_cnt++; if (o_count !== 6'd7) $display("[TB] FAIL deal_count got %0d want 7", o_count); else pass_cnt++;
    for (int i = 0; i < model_hand.size(); i++) begin
      i_sel = i[IDX_W-1:0];
      tick();
      check_cnt++; if (o_sel_card !== model_hand[i]) $display("[TB] FAIL deal_hand[%0d] got %h want %h", i, o_sel_card, model_hand[i]); else pass_cnt++;
    end
  endtask

  task automatic test_draw4();
    i_draw_req = 3'b100;
    tick();
    i_draw_req = 3'b000;
    tick();
    strobe(6'h05);
    tick();
    tick();
    strobe(6'h1A);
    strobe(6'h2B);
    tick();
    tick();
    check_cnt++; if (o_busy !== 1'b1 || deck.o_draw !== 3'b100) $display("[TB] FAIL draw4_gap got busy=%b draw=%b want 1/100", o_busy, deck.o_draw); else pass_cnt++;
    strobe(6'h3C);
    check_cnt++; if (o_busy !== 1'b0 || deck.o_draw !== 3'b000) $display("[TB] FAIL draw4_end got busy=%b draw=%b want 0/000", o_busy, deck.o_draw); else pass_cnt++;
    check_cnt++; if (o_count !== 6'd11) $display("[TB] FAIL draw4_count got %0d want 11", o_count); else pass_cnt++;
    for (int i = 7; i < model_hand.size(); i++) begin
      i_sel = i[IDX_W-1:0];
      tick();
      check_cnt++; if (o_sel_card !== model_hand[i]) $display("[TB] FAIL draw4_hand[%0d] got %h want %h", i, o_sel_card, model_hand[i]); else pass_cnt++;
    end
  endtask

  task automatic test_play_shift();
    logic [5:0] exp;
    apply_reset();
    i_draw_req = 3'b100;
    tick();
    i_draw_req = 3'b000;
    strobe(6'h01);
    strobe(6'h12);
    strobe(6'h23);
    strobe(6'h34);
    i_top_card = 6'h27;
    i_sel = 5'd2;
    i_play = 1'b1;
    exp_q.push_back(model_hand[2]);
    model_hand.delete(2);
    tick();
    i_play = 1'b0;
    exp = exp_q.pop_front();
    check_cnt++; if (deck.o_insert !== 1'b1 || deck.o_play_card !== exp) $display("[TB] FAIL shift_insert got ins=%b card=%h want 1/%h", deck.o_insert, deck.o_play_card, exp); else pass_cnt++;
    check_cnt++; if (o_count !== 6'd3 || o_busy !== 1'b1) $display("[TB] FAIL shift_state got count=%0d busy=%b want 3/1", o_count, o_busy); else pass_cnt++;
    tick();
    check_cnt++; if (deck.o_insert !== 1'b0 || o_busy !== 1'b0) $display("[TB] FAIL shift_done got ins=%b busy=%b want 0/0", deck.o_insert, o_busy); else pass_cnt++;
    for (int i = 0; i < model_hand.size(); i++) begin
      i_sel = i[IDX_W-1:0];
      tick();
      check_cnt++; if (o_sel_card !== model_hand[i]) $display("[TB] FAIL shift_hand[%0d] got %h want %h", i, o_sel_card, model_hand[i]); else pass_cnt++;
    end
    i_sel = 5'd3;
    #1;
    check_cnt++; if (o_sel_card !== 6'd0) $display("[TB] FAIL shift_beyond got %h want 00", o_sel_card); else pass_cnt++;
  endtask

  task automatic test_wild();
    logic [5:0] exp;
    i_top_card = 6'h0D;
    i_wild_color = 2'd3;
    i_sel = 5'd0;
    i_play = 1'b1;
    tick();
    i_play = 1'b0;
    check_cnt++; if (o_illegal !== 1'b1 || deck.o_insert !== 1'b0) $display("[TB] FAIL wild_reject got ill=%b ins=%b want 1/0", o_illegal, deck.o_insert); else pass_cnt++;
    check_cnt++; if (o_count !== 6'd3) $display("[TB] FAIL wild_reject_count got %0d want 3", o_count); else pass_cnt++;
    tick();
    check_cnt++; if (o_illegal !== 1'b0) $display("[TB] FAIL illegal_pulse got %b want 0", o_illegal); else pass_cnt++;
    i_sel = 5'd2;
    i_play = 1'b1;
    exp_q.push_back(model_hand[2]);
    model_hand.delete(2);
    tick();
    i_play = 1'b0;
    exp = exp_q.pop_front();
    check_cnt++; if (deck.o_insert !== 1'b1 || deck.o_play_card !== exp) $display("[TB] FAIL wild_accept got ins=%b card=%h want 1/%h", deck.o_insert, deck.o_play_card, exp); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b0 || o_count !== 6'd2) $display("[TB] FAIL last_play got busy=%b count=%0d want 0/2", o_busy, o_count); else pass_cnt++;
    i_sel = 5'd5;
    i_play = 1'b1;
    tick();
    i_play = 1'b0;
    check_cnt++; if (o_illegal !== 1'b1 || o_count !== 6'd2) $display("[TB] FAIL sel_range got ill=%b count=%0d want 1/2", o_illegal, o_count); else pass_cnt++;
    i_top_card = 6'h21;
    i_sel = 5'd0;
    i_play = 1'b1;
    exp_q.push_back(model_hand[0]);
    model_hand.delete(0);
    tick();
    i_play = 1'b0;
    exp = exp_q.pop_front();
    check_cnt++; if (deck.o_insert !== 1'b1 || deck.o_play_card !== exp) $display("[TB] FAIL value_match got ins=%b card=%h want 1/%h", deck.o_insert, deck.o_play_card, exp); else pass_cnt++;
    tick();
    check_cnt++; if (o_uno !== 1'b1 || o_busy !== 1'b0) $display("[TB] FAIL uno got uno=%b busy=%b want 1/0", o_uno, o_busy); else pass_cnt++;
    check_cnt++; if (o_sel_card !== model_hand[0]) $display("[TB] FAIL value_hand got %h want %h", o_sel_card, model_hand[0]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    i_top_card = 6'h12;
    i_sel = 5'd0;
    i_draw_req = 3'b001;
    i_play = 1'b1;
    tick();
    i_draw_req = 3'b000;
    check_cnt++; if (deck.o_insert !== 1'b0 || o_illegal !== 1'b0) $display("[TB] FAIL prio_drop got ins=%b ill=%b want 0/0", deck.o_insert, o_illegal); else pass_cnt++;
    check_cnt++; if (o_busy !== 1'b1 || deck.o_draw !== 3'b001) $display("[TB] FAIL prio_draw got busy=%b draw=%b want 1/001", o_busy, deck.o_draw); else pass_cnt++;
    i_deal = 1'b1;
    tick();
    i_play = 1'b0;
    i_deal = 1'b0;
    check_cnt++; if (deck.o_insert !== 1'b0 || deck.o_draw !== 3'b001 || o_count !== 6'd1) $display("[TB] FAIL busy_ignore got ins=%b draw=%b count=%0d want 0/001/1", deck.o_insert, deck.o_draw, o_count); else pass_cnt++;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    model_hand.delete();
    check_cnt++; if (o_count !== 6'd0 || deck.o_draw !== 3'b000 || o_busy !== 1'b0) $display("[TB] FAIL rst_draw got count=%0d draw=%b busy=%b want 0/000/0", o_count, deck.o_draw, o_busy); else pass_cnt++;
    deck.i_deck_drawn = 1'b1;
    deck.i_deck_card  = 6'h15;
    tick();
    deck.i_deck_drawn = 1'b0;
    check_cnt++; if (o_count !== 6'd0) $display("[TB] FAIL idle_strobe got count=%0d want 0", o_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [5:0] c;
    apply_reset();
    i_deal = 1'b1;
    tick();
    i_deal = 1'b0;
    for (int k = 0; k < 7; k++) begin
      c = {k[1:0], 4'(k % 15)};
      strobe(c);
    end
    for (int r = 0; r < 6; r++) begin
      i_draw_req = 3'b100;
      tick();
      i_draw_req = 3'b000;
      for (int k = 0; k < 4; k++) begin
        c = {r[1:0], 4'((r * 4 + k) % 15)};
        strobe(c);
      end
    end
    check_cnt++; if (o_count !== 6'd31) $display("[TB] FAIL ovf_fill got %0d want 31", o_count); else pass_cnt++;
    i_draw_req = 3'b010;
    tick();
    i_draw_req = 3'b000;
    strobe(6'h39);
    check_cnt++; if (o_count !== 6'd32 || o_overflow !== 1'b0 || deck.o_draw !== 3'b010) $display("[TB] FAIL ovf_last_fit got count=%0d ovf=%b draw=%b want 32/0/010", o_count, o_overflow, deck.o_draw); else pass_cnt++;
    strobe(6'h2A);
    check_cnt++; if (o_overflow !== 1'b1 || o_count !== 6'd32) $display("[TB] FAIL ovf_drop got ovf=%b count=%0d want 1/32", o_overflow, o_count); else pass_cnt++;
    check_cnt++; if (deck.o_draw !== 3'b000 || o_busy !== 1'b0) $display("[TB] FAIL ovf_end got draw=%b busy=%b want 000/0", deck.o_draw, o_busy); else pass_cnt++;
    i_sel = 5'd31;
    tick();
    check_cnt++; if (o_overflow !== 1'b0) $display("[TB] FAIL ovf_pulse got %b want 0", o_overflow); else pass_cnt++;
    check_cnt++; if (o_sel_card !== model_hand[31]) $display("[TB] FAIL ovf_hand31 got %h want %h", o_sel_card, model_hand[31]); else pass_cnt++;
  endtask

  initial begin
    deck.i_deck_drawn = 1'b0;
    deck.i_deck_card  = 6'd0;
    test_reset();
    test_deal();
    test_draw4();
    test_play_shift();
    test_wild();
    test_back_to_back();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached after %0d of %0d checks", pass_cnt, check_cnt);
    $fatal(1, "[TB] watchdog");
  end
endmodule
